param_sync_fifo: RTL and testbench

//   Parametrised single-clock FIFO; successor to the fixed 8-bit x 4 FIFO.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/param_sync_fifo_if.sv | 33 +++
 rtl/fifo_ptr_ctrl.sv | 67 ++++++
 rtl/param_sync_fifo.sv | 64 ++++++
 tb/tb_param_sync_fifo.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family: default sizes and elaboration helpers.
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 4;

  // Ceiling log2 for sizing address fields; clog2(1) = 0.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result++;
      rem = rem >> 1;
    end
    return result;
  endfunction

  function automatic bit is_pow2(input int value);
    return (value >= 2) && ((value & (value - 1)) == 0);
  endfunction

endpackage

// File: rtl/param_sync_fifo_if.sv
// Handshake/status bundle between a producer/consumer and param_sync_fifo.
interface param_sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int ADDR_W = clog2(DEPTH);

  logic              flush;
  logic              write_en;
  logic [DATA_W-1:0] data_in;
  logic              read_en;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, write_en, data_in, read_en,
    input  data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  flush, write_en, data_in, read_en,
    output data_out, full, empty, almost_full, almost_empty, count, overflow, underflow
  );

endinterface

// File: rtl/fifo_ptr_ctrl.sv
// Pointer bookkeeping for the FIFO: accept decisions, occupancy, flags and error pulses.
module fifo_ptr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1,
  localparam int ADDR_W   = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              write_en,
  input  logic              read_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W:0] PTR_ONE = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0] AF_C    = AF_THRESH[ADDR_W:0];
  localparam logic [ADDR_W:0] AE_C    = AE_THRESH[ADDR_W:0];

  // MSB of each pointer is the wrap bit; the low bits address the memory.
  logic [ADDR_W:0] wr_ptr;
  logic [ADDR_W:0] rd_ptr;
  logic            rd_acc;
  logic            wr_acc;

  assign wr_addr = wr_ptr[ADDR_W-1:0];
  assign rd_addr = rd_ptr[ADDR_W-1:0];
  assign count   = wr_ptr - rd_ptr;
  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_addr == rd_addr) && (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);
  assign almost_full  = (count >= AF_C);
  assign almost_empty = (count <= AE_C);

  // A full FIFO still takes a write when the head is popped in the same cycle.
  assign rd_acc = read_en & ~empty;
  assign wr_acc = write_en & (~full | rd_acc);

  // Memory must not be touched by writes that flush or reset discard.
  assign mem_we = wr_acc & ~flush & ~rst;

  // Advance pointers on accepted transfers; register one-cycle rejection pulses.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_acc) rd_ptr <= rd_ptr + PTR_ONE;
      overflow  <= write_en & ~wr_acc;
      underflow <= read_en & ~rd_acc;
    end
  end

endmodule

// File: rtl/param_sync_fifo.sv
// Parametrised single-clock show-ahead FIFO: storage array plus gated head output.
module param_sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int AF_THRESH = 3,
  parameter int AE_THRESH = 1
) (
  input  logic             clk,
  input  logic             rst,
  param_sync_fifo_if.slave bus
);

  localparam int ADDR_W = clog2(DEPTH);

  if (!is_pow2(DEPTH)) begin : g_bad_depth
    $fatal(1, "param_sync_fifo: DEPTH must be a power of two >= 2");
  end
  if (DATA_W < 1) begin : g_bad_width
    $fatal(1, "param_sync_fifo: DATA_W must be >= 1");
  end
  if (AF_THRESH < 1 || AF_THRESH > DEPTH) begin : g_bad_af
    $fatal(1, "param_sync_fifo: AF_THRESH out of range 1..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH > DEPTH - 1) begin : g_bad_ae
    $fatal(1, "param_sync_fifo: AE_THRESH out of range 0..DEPTH-1");
  end

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;

  fifo_ptr_ctrl #(
    .DEPTH     (DEPTH),
    .AF_THRESH (AF_THRESH),
    .AE_THRESH (AE_THRESH)
  ) u_ptr_ctrl (
    .clk          (clk),
    .rst          (rst),
    .flush        (bus.flush),
    .write_en     (bus.write_en),
    .read_en      (bus.read_en),
    .mem_we       (mem_we),
    .wr_addr      (wr_addr),
    .rd_addr      (rd_addr),
    .count        (bus.count),
    .full         (bus.full),
    .empty        (bus.empty),
    .almost_full  (bus.almost_full),
    .almost_empty (bus.almost_empty),
    .overflow     (bus.overflow),
    .underflow    (bus.underflow)
  );

  // Storage is deliberately left unreset; empty gating hides stale contents.
  always_ff @(posedge clk) begin
    if (mem_we) mem[wr_addr] <= bus.data_in;
  end

  assign bus.data_out = bus.empty ? '0 : mem[rd_addr];

endmodule

// File: tb/tb_param_sync_fifo.sv
// Drives a default FIFO and a 16x16 FIFO with identical controls; checks both against queue models.
module tb_param_sync_fifo;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  param_sync_fifo_if #(.DATA_W(8),  .DEPTH(4))  b0 ();
  param_sync_fifo_if #(.DATA_W(16), .DEPTH(16)) b1 ();

  param_sync_fifo #(.DATA_W(8), .DEPTH(4), .AF_THRESH(3), .AE_THRESH(1))
    dut0 (.clk(clk), .rst(rst), .bus(b0.slave));
  param_sync_fifo #(.DATA_W(16), .DEPTH(16), .AF_THRESH(12), .AE_THRESH(2))
    dut1 (.clk(clk), .rst(rst), .bus(b1.slave));

  int checks   = 0;
  int failures = 0;

  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  bit ov0, ud0, ov1, ud1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n0, n1;
    n0 = q0.size();
    n1 = q1.size();
    chk("d0.count", 32'(b0.count), 32'(n0));
    chk("d0.data_out", 32'(b0.data_out), (n0 > 0) ? 32'(q0[0]) : 32'd0);
    chk("d0.full", 32'(b0.full), 32'(n0 == 4));
    chk("d0.empty", 32'(b0.empty), 32'(n0 == 0));
    chk("d0.almost_full", 32'(b0.almost_full), 32'(n0 >= 3));
    chk("d0.almost_empty", 32'(b0.almost_empty), 32'(n0 <= 1));
    chk("d0.overflow", 32'(b0.overflow), 32'(ov0));
    chk("d0.underflow", 32'(b0.underflow), 32'(ud0));
    chk("d1.count", 32'(b1.count), 32'(n1));
    chk("d1.data_out", 32'(b1.data_out), (n1 > 0) ? 32'(q1[0]) : 32'd0);
    chk("d1.full", 32'(b1.full), 32'(n1 == 16));
    chk("d1.empty", 32'(b1.empty), 32'(n1 == 0));
    chk("d1.almost_full", 32'(b1.almost_full), 32'(n1 >= 12));
    chk("d1.almost_empty", 32'(b1.almost_empty), 32'(n1 <= 2));
    chk("d1.overflow", 32'(b1.overflow), 32'(ov1));
    chk("d1.underflow", 32'(b1.underflow), 32'(ud1));
  endtask

  // One clock of stimulus: apply inputs, advance the models at the edge, then compare.
  task automatic step(input bit r, input bit fl, input bit we, input bit re, input logic [15:0] d);
    bit ra, wa;
    rst         = r;
    b0.flush    = fl;
    b1.flush    = fl;
    b0.write_en = we;
    b1.write_en = we;
    b0.read_en  = re;
    b1.read_en  = re;
    b0.data_in  = d[7:0];
    b1.data_in  = d;
    @(posedge clk);
    if (r || fl) begin
      q0.delete();
      q1.delete();
      ov0 = 0; ud0 = 0; ov1 = 0; ud1 = 0;
    end else begin
      ra  = re && (q0.size() > 0);
      wa  = we && ((q0.size() < 4) || ra);
      ov0 = we && !wa;
      ud0 = re && !ra;
      if (ra) void'(q0.pop_front());
      if (wa) q0.push_back({8'h00, d[7:0]});
      ra  = re && (q1.size() > 0);
      wa  = we && ((q1.size() < 16) || ra);
      ov1 = we && !wa;
      ud1 = re && !ra;
      if (ra) void'(q1.pop_front());
      if (wa) q1.push_back(d);
    end
    #1;
    check_all();
  endtask

  logic [15:0] t1_data [4] = '{16'h10A1, 16'h20B2, 16'h30C3, 16'h40D4};

  initial begin
    step(1, 0, 0, 0, 16'h0);
    chk("reset.empty", 32'(b0.empty), 32'd1);
    chk("reset.data_out", 32'(b0.data_out), 32'd0);

    // Fill to full, then one rejected write.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, t1_data[i]);
    chk("t1.full", 32'(b0.full), 32'd1);
    step(0, 0, 1, 0, 16'h50EE);
    chk("t1.overflow", 32'(b0.overflow), 32'd1);
    chk("t1.count", 32'(b0.count), 32'd4);

    // Drain in order, then one rejected read.
    for (int i = 0; i < 4; i++) begin
      chk("t2.head", 32'(b0.data_out), 32'(t1_data[i][7:0]));
      step(0, 0, 0, 1, 16'h0);
    end
    chk("t2.data_out_empty", 32'(b0.data_out), 32'd0);
    step(0, 0, 0, 1, 16'h0);
    chk("t2.underflow", 32'(b0.underflow), 32'd1);
    step(0, 0, 0, 0, 16'h0);
    chk("t2.underflow_clear", 32'(b0.underflow), 32'd0);

    // Pass-through on full.
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, t1_data[i]);
    step(0, 0, 1, 1, 16'h6055);
    chk("t3.count", 32'(b0.count), 32'd4);
    chk("t3.no_overflow", 32'(b0.overflow), 32'd0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1, 16'h0);
    chk("t3.last", 32'(b0.data_out), 32'h55);
    step(0, 0, 0, 1, 16'h0);

    // Read and write together while empty.
    step(0, 0, 1, 1, 16'h7077);
    chk("t4.count", 32'(b0.count), 32'd1);
    chk("t4.data_out", 32'(b0.data_out), 32'h77);
    chk("t4.underflow", 32'(b0.underflow), 32'd1);
    step(0, 0, 0, 1, 16'h0);

    // Interleaved traffic across pointer wrap.
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 1, 0, 16'(16'h0100 + 2 * k));
      step(0, 0, 1, 1, 16'(16'h0101 + 2 * k));
      step(0, 0, 1, 0, 16'(16'h0180 + k));
      step(0, 0, 0, 1, 16'h0);
      step(0, 0, 0, 1, 16'h0);
      step(0, 0, 0, 1, 16'h0);
    end

    // Flush with a concurrent write, then reset mid-stream.
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 16'(16'h0A00 + i));
    step(0, 1, 1, 0, 16'h0BBB);
    chk("t6.flush_count", 32'(b0.count), 32'd0);
    chk("t6.flush_no_ovf", 32'(b0.overflow), 32'd0);
    step(0, 0, 1, 0, 16'h0C01);
    step(0, 0, 1, 0, 16'h0C02);
    step(1, 0, 1, 1, 16'h0C03);
    chk("t6.rst_count", 32'(b1.count), 32'd0);

    // Exercise the deep FIFO through full and back to empty.
    for (int i = 0; i < 18; i++) step(0, 0, 1, 0, 16'($urandom));
    chk("deep.full", 32'(b1.full), 32'd1);
    for (int i = 0; i < 18; i++) step(0, 0, 0, 1, 16'h0);

    // Randomised traffic with fill-biased, drain-biased and balanced phases.
    for (int i = 0; i < 900; i++) begin
      int phase;
      int wp;
      phase = (i / 100) % 3;
      wp = (phase == 0) ? 75 : ((phase == 1) ? 25 : 50);
      step(($urandom % 211) == 0, ($urandom % 47) == 0,
           ($urandom % 100) < wp, ($urandom % 100) < (100 - wp),
           16'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
